// File: rtl/vga_pkg.sv
`default_nettype none
// vga_pkg: frame geometry, bus widths, writer FSM encoding and request check (rev 1.0)
package vga_pkg;
  localparam int H_RES  = 800;
  localparam int V_RES  = 600;
  localparam int ADDR_W = 19;
  localparam int DATA_W = 8;
  localparam int GEOM_W = 11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } wr_state_e;

  // Edge sums use one extra bit so an out-of-range request can never wrap into range.
  function automatic logic rect_ok(input logic [GEOM_W-1:0] x, input logic [GEOM_W-1:0] y,
                                   input logic [GEOM_W-1:0] w, input logic [GEOM_W-1:0] h);
    logic [GEOM_W:0] x_end;
    logic [GEOM_W:0] y_end;
    x_end = {1'b0, x} + {1'b0, w};
    y_end = {1'b0, y} + {1'b0, h};
    return (w != '0) && (h != '0) &&
           (x_end <= (GEOM_W+1)'(H_RES)) && (y_end <= (GEOM_W+1)'(V_RES));
  endfunction
endpackage
`default_nettype wire

// File: rtl/fb_rect_writer_if.sv
`default_nettype none
// fb_rect_writer_if: pixel stream in, image-RAM write port out (rev 1.0)
interface fb_rect_writer_if;
  import vga_pkg::*;

  logic              s_valid;
  logic [DATA_W-1:0] s_data;
  logic              s_ready;
  logic              we;
  logic [ADDR_W-1:0] write_address;
  logic [DATA_W-1:0] d;

  modport master (output s_valid, output s_data, input s_ready,
                  input we, input write_address, input d);
  modport slave  (input s_valid, input s_data, output s_ready,
                  output we, output write_address, output d);
endinterface
`default_nettype wire

// File: rtl/fb_rect_writer.sv
`default_nettype none
// fb_rect_writer: writes a colour-index stream into a rectangle of the frame buffer (rev 1.0)
module fb_rect_writer
  import vga_pkg::*;
(
  input  logic              sys_clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [GEOM_W-1:0] x0,
  input  logic [GEOM_W-1:0] y0,
  input  logic [GEOM_W-1:0] width,
  input  logic [GEOM_W-1:0] height,
  output logic              busy,
  output logic              done,
  output logic              err,
  fb_rect_writer_if.slave   wr_if
);
  localparam logic [ADDR_W-1:0] c_STRIDE = ADDR_W'(H_RES);

  wr_state_e         state_q, state_d;
  logic [GEOM_W-1:0] x0_q, x0_d, y0_q, y0_d, w_q, w_d, h_q, h_d;
  logic [GEOM_W-1:0] col_q, col_d, row_q, row_d;
  logic [ADDR_W-1:0] line_base_q, line_base_d, cur_addr_q, cur_addr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              we_q, we_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic              beat;

  assign wr_if.s_ready       = (state_q == ST_WRITE);
  assign beat                = wr_if.s_valid & wr_if.s_ready;
  assign wr_if.we            = we_q;
  assign wr_if.write_address = addr_q;
  assign wr_if.d             = data_q;
  assign busy                = busy_q;
  assign done                = done_q;
  assign err                 = err_q;

  always_comb begin
    state_d     = state_q;
    x0_d        = x0_q;
    y0_d        = y0_q;
    w_d         = w_q;
    h_d         = h_q;
    col_d       = col_q;
    row_d       = row_q;
    line_base_d = line_base_q;
    cur_addr_d  = cur_addr_q;
    addr_d      = addr_q;
    data_d      = data_q;
    we_d        = 1'b0;
    err_d       = err_q;
    done_d      = (state_q == ST_DONE);

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (rect_ok(x0, y0, width, height)) begin
            err_d   = 1'b0;
            x0_d    = x0;
            y0_d    = y0;
            w_d     = width;
            h_d     = height;
            state_d = ST_SETUP;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_SETUP: begin
        line_base_d = ADDR_W'(y0_q) * c_STRIDE + ADDR_W'(x0_q);
        cur_addr_d  = ADDR_W'(y0_q) * c_STRIDE + ADDR_W'(x0_q);
        col_d       = '0;
        row_d       = '0;
        state_d     = abort ? ST_IDLE : ST_WRITE;
      end
      ST_WRITE: begin
        if (beat) begin
          we_d   = 1'b1;
          addr_d = cur_addr_q;
          data_d = wr_if.s_data;
          if (col_q == w_q - 11'd1) begin
            col_d       = '0;
            row_d       = row_q + 11'd1;
            line_base_d = line_base_q + c_STRIDE;
            cur_addr_d  = line_base_q + c_STRIDE;
            if (row_q == h_q - 11'd1) state_d = ST_DONE;
          end else begin
            col_d      = col_q + 11'd1;
            cur_addr_d = cur_addr_q + 1'b1;
          end
        end
        // The beat above is still committed; only the transfer is dropped.
        if (abort) state_d = ST_IDLE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      x0_q        <= '0;
      y0_q        <= '0;
      w_q         <= '0;
      h_q         <= '0;
      col_q       <= '0;
      row_q       <= '0;
      line_base_q <= '0;
      cur_addr_q  <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      we_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      x0_q        <= x0_d;
      y0_q        <= y0_d;
      w_q         <= w_d;
      h_q         <= h_d;
      col_q       <= col_d;
      row_q       <= row_d;
      line_base_q <= line_base_d;
      cur_addr_q  <= cur_addr_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      we_q        <= we_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end
endmodule
`default_nettype wire

// File: doc/fb_rect_writer.md
Name: fb_rect_writer

Overview:
- Frame-buffer writer: the producer side of the 800x600 indexed-colour image RAM that the VGA scan-out path reads.
- Accepts a valid/ready stream of 8-bit colour indices and writes them into a host-specified rectangle of the frame buffer.
- Drives the RAM write port (d, write_address, we), generating raster-order linear addresses with per-line stride.
- Sits in the sys_clk domain alongside the image RAM.

Parameters:
- H_RES, 800, frame width in pixels; also the line stride.
- V_RES, 600, frame height in lines.
- ADDR_W, 19, RAM address width; must satisfy H_RES*V_RES <= 2^ADDR_W.
- DATA_W, 8, colour-index width.

Ports:
- sys_clk  in  1  sole clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request; latches x0/y0/width/height
- abort  in  1  cancels the transfer in progress
- x0  in  11  rectangle left column
- y0  in  11  rectangle top line
- width  in  11  rectangle width in pixels
- height  in  11  rectangle height in lines
- s_valid  in  1  stream data valid
- s_data  in  DATA_W  colour index
- s_ready  out  1  writer accepts stream data
- we  out  1  RAM write enable
- write_address  out  ADDR_W  RAM write address
- d  out  DATA_W  RAM write data
- busy  out  1  high from accepted start until done/abort
- done  out  1  one-cycle pulse after the last pixel is written
- err  out  1  sticky rejected-request flag; cleared by the next accepted start

Behaviour:
- Reset (async, active-high): all outputs are 0, state IDLE, counters 0.
- FSM states: IDLE -> SETUP -> WRITE -> DONE -> IDLE.
- IDLE:
  - s_ready=0, busy=0.
  - On start, validate the request: width!=0, height!=0, x0+width<=H_RES, y0+height<=V_RES. Evaluate sums at 12 bits, no wrap.
  - If invalid: err=1, remain in IDLE.
  - If valid: err=0, latch the geometry, go to SETUP.
- SETUP (1 cycle):
  - line_base = y0*H_RES + x0 (registered; the single multiply occurs only here).
  - cur_addr = that same value, col=0, row=0, busy=1.
- WRITE:
  - s_ready=1.
  - Each beat (s_valid & s_ready): next cycle we=1, write_address=cur_addr, d=s_data. Write latency is exactly 1 cycle; with no beat, we=0.
  - Within a line: col++, cur_addr++.
  - At col==width-1: col=0, row++, line_base += H_RES, cur_addr = line_base + H_RES. Add only; no multiply.
  - At the beat with col==width-1 and row==height-1, go to DONE. s_ready drops in the same cycle the state leaves WRITE, so at most width*height beats are accepted.
- DONE (1 cycle): done=1, busy=0 next cycle, return to IDLE.
- abort:
  - In SETUP or WRITE: next state is IDLE and s_ready=0 next cycle.
  - A beat accepted in the abort cycle is still written; no done pulse.
  - In IDLE or DONE: abort is ignored.
- start while busy is ignored and does not set err.
- Simultaneous start and abort in IDLE: start wins.
- Stalls: s_valid low leaves all counters unchanged. Bubbles are allowed anywhere.
- write_address never exceeds H_RES*V_RES-1 for an accepted request.
- d and write_address hold their last values when we=0.

Decomposition:
- Shared package vga_pkg holds H_RES, V_RES, ADDR_W, DATA_W and the FSM state encoding.
- vga_sync_generator also uses these constants.
- No sub-module: the bounds check and address stepping are inline.

Test Plan:
- Full frame: start x0=0, y0=0, width=800, height=600, with a continuous stream -> 480000 writes, addresses 0..479999 consecutive, done 1 cycle after the final we, busy low afterwards.
- Sub-rectangle: x0=10, y0=5, width=3, height=2, data 1..6 -> writes (4010,1), (4011,2), (4012,3), (4810,4), (4811,5), (4812,6); then done.
- Backpressure and bubbles: the same rectangle with s_valid toggled randomly -> identical address/data sequence, and we never asserted without a preceding beat.
- Bounds: x0=799, width=2 -> err=1, busy=0, no we. A following valid start clears err.
- Abort: abort after 3 beats of a 4x4 request -> exactly 3 writes, no done, s_ready=0; a new start then works normally.
- Async reset asserted mid-WRITE -> all outputs 0 immediately, without waiting for a clock edge; the state is IDLE after release.
